// File: rtl/coin_return_sequencer.sv
// Coin return sequencer: pays out a requested amount as dimes then nickels, one coin per hopper ack.
// Define COIN_INVENTORY_EN to enable finite coin inventories, restocking and shortage reporting.
module coin_return_sequencer #(
    parameter int unsigned N            = 6,
    parameter int unsigned INV_W        = 4,
    parameter int unsigned INIT_DIMES   = 10,
    parameter int unsigned INIT_NICKELS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    input  logic [N-1:0] req_amount,
    output logic         req_ready,
    input  logic         coin_ack,
    input  logic         load_dime,
    input  logic         load_nickel,
    output logic         dime_out,
    output logic         nickel_out,
    output logic         busy,
    output logic         done,
    output logic         short_out
);

    typedef enum logic [1:0] {StIdle, StDispense, StWaitAck, StDone} state_e;

    localparam logic [N-1:0] FIVE = N'(5);
    localparam logic [N-1:0] TEN  = N'(10);

    state_e       state;
    logic [N-1:0] remaining;
    logic [N-1:0] rounded_amount;
    logic         dime_avail;
    logic         nickel_avail;
    logic         can_dime;
    logic         can_nickel;
    logic         take_dime;
    logic         take_nickel;

    // Odd cents cannot be paid in dimes/nickels, so drop them up front.
    assign rounded_amount = req_amount - (req_amount % FIVE);

    assign can_dime    = (remaining >= TEN) && dime_avail;
    assign can_nickel  = (remaining >= FIVE) && nickel_avail;
    assign take_dime   = (state == StDispense) && can_dime;
    assign take_nickel = (state == StDispense) && !can_dime && can_nickel;

    assign req_ready = (state == StIdle);
    assign busy      = (state != StIdle);

`ifdef COIN_INVENTORY_EN
    localparam logic [INV_W-1:0] INV_MAX = '1;

    logic [INV_W-1:0] dime_inv;
    logic [INV_W-1:0] nickel_inv;

    assign dime_avail   = (dime_inv != '0);
    assign nickel_avail = (nickel_inv != '0);

    // A restock and a payout in the same cycle cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dime_inv   <= INV_W'(INIT_DIMES);
            nickel_inv <= INV_W'(INIT_NICKELS);
        end else begin
            if (load_dime && !take_dime) begin
                if (dime_inv != INV_MAX) begin
                    dime_inv <= dime_inv + 1'b1;
                end
            end else if (take_dime && !load_dime) begin
                dime_inv <= dime_inv - 1'b1;
            end

            if (load_nickel && !take_nickel) begin
                if (nickel_inv != INV_MAX) begin
                    nickel_inv <= nickel_inv + 1'b1;
                end
            end else if (take_nickel && !load_nickel) begin
                nickel_inv <= nickel_inv - 1'b1;
            end
        end
    end
`else
    logic        unused_load;
    logic [31:0] unused_cfg;

    assign dime_avail   = 1'b1;
    assign nickel_avail = 1'b1;
    assign short_out    = 1'b0;
    assign unused_load  = load_dime ^ load_nickel;
    assign unused_cfg   = 32'(INIT_DIMES + INIT_NICKELS + INV_W);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            remaining  <= '0;
            dime_out   <= 1'b0;
            nickel_out <= 1'b0;
            done       <= 1'b0;
`ifdef COIN_INVENTORY_EN
            short_out  <= 1'b0;
`endif
        end else begin
            dime_out   <= 1'b0;
            nickel_out <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        remaining <= rounded_amount;
`ifdef COIN_INVENTORY_EN
                        short_out <= 1'b0;
`endif
                        state     <= StDispense;
                    end
                end
                StDispense: begin
                    if (take_dime) begin
                        dime_out  <= 1'b1;
                        remaining <= remaining - TEN;
                        state     <= StWaitAck;
                    end else if (take_nickel) begin
                        nickel_out <= 1'b1;
                        remaining  <= remaining - FIVE;
                        state      <= StWaitAck;
                    end else begin
                        // Nothing left to pay, or no usable coin: a non-zero balance is a shortage.
`ifdef COIN_INVENTORY_EN
                        short_out <= (remaining != '0);
`endif
                        done      <= 1'b1;
                        state     <= StDone;
                    end
                end
                StWaitAck: begin
                    if (coin_ack) begin
                        state <= StDispense;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    a_one_coin: assert property (@(posedge clk) disable iff (reset) !(dime_out && nickel_out));
    a_whole_nickels: assert property (@(posedge clk) disable iff (reset) (remaining % FIVE) == '0);

endmodule

// File: doc/coin_return_sequencer.md
COIN_RETURN_SEQUENCER -- requirements
Module: coin_return_sequencer

Interface
REQ-001 Parameter N, 6, width of req_amount in cents.
REQ-002 Parameter INV_W, 4, width of each coin inventory counter.
REQ-003 Parameter INIT_DIMES, 10, dime inventory loaded at reset.
REQ-004 Parameter INIT_NICKELS, 10, nickel inventory loaded at reset.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on posedge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 req_valid  input  1  request to return req_amount.
REQ-009 req_amount  input  N  amount to return, in cents.
REQ-010 req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready.
REQ-011 coin_ack  input  1  hopper confirms the last coin left the machine.
REQ-012 load_dime  input  1  restock one dime.
REQ-013 load_nickel  input  1  restock one nickel.
REQ-014 dime_out  output  1  one-cycle pulse, dispense one dime.
REQ-015 nickel_out  output  1  one-cycle pulse, dispense one nickel.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse at completion.
REQ-018 short_out  output  1  request ended with a shortage; valid with done, held until next accept.

Function
REQ-019 FSM states SHALL be IDLE, DISPENSE, WAIT_ACK and DONE; all outputs are registered or Moore-decoded.
REQ-020 IDLE: on accept, latch remaining = req_amount rounded down to a multiple of 5, clear short_out, go to DISPENSE.
REQ-021 DISPENSE: if remaining>=10 and dime_inv>0, pulse dime_out, subtract 10, go to WAIT_ACK.
REQ-022 DISPENSE otherwise: if remaining>=5 and nickel_inv>0, pulse nickel_out, subtract 5, go to WAIT_ACK.
REQ-023 DISPENSE with remaining==0 SHALL go to DONE with short_out=0.
REQ-024 DISPENSE with remaining>0 and no coin usable SHALL set short_out=1 and go to DONE.
REQ-025 WAIT_ACK SHALL hold until coin_ack=1, then return to DISPENSE; no coin pulses while waiting.
REQ-026 coin_ack SHALL be ignored outside WAIT_ACK.
REQ-027 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-028 req_valid outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-029 Each coin pulse SHALL decrement its inventory counter in the same cycle.
REQ-030 load_* SHALL increment its counter, saturating at 2^INV_W-1; load and dispense in one cycle SHALL leave the count unchanged.
REQ-031 The subtraction on remaining SHALL never underflow, because of the guards in REQ-021 and REQ-022.

Reset
REQ-032 Reset SHALL force IDLE, remaining=0, and dime_out, nickel_out, done, busy and short_out all to 0.
REQ-033 Reset SHALL load dime_inv=INIT_DIMES and nickel_inv=INIT_NICKELS.
REQ-034 Reset mid-operation SHALL abort with no further pulses; req_ready=1 on the first clock after release.

Configuration
REQ-035 Macro COIN_INVENTORY_EN defined: inventory counters, restock and shortage behaviour are implemented as specified above.
REQ-036 Macro COIN_INVENTORY_EN undefined: inventory is treated as unlimited, load_* are ignored and short_out is tied to 0.

Verification
REQ-037 req 15, coin_ack 1 cycle after each pulse -> dime_out, then nickel_out, then done; short_out=0.
REQ-038 req 0 -> no coin pulses; done 2 cycles after accept.
REQ-039 req 17 -> treated as 15: one dime, one nickel, done, short_out=0.
REQ-040 Macro on, INIT_DIMES=0, req 20 -> four nickel_out pulses; nickel_inv drops 10->6.
REQ-041 Macro on, INIT_DIMES=0, INIT_NICKELS=1, req 20 -> one nickel_out, then done with short_out=1.
REQ-042 Reset asserted in WAIT_ACK after a dime pulse -> outputs 0, dime_inv=INIT_DIMES, req_ready=1 after release.
